// File: rtl/mvp_pkg.sv
// Shared definitions for the mvp datapath: accumulator FSM states and
// precision/shift limits used by mvp_accum and its lanes.
package mvp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUT
  } accum_state_t;

  localparam int PREC_W       = 3;
  localparam int MAX_SHIFT    = 14;
  localparam int SHIFT_W      = 4;
  localparam int DEFAULT_ACCW = 32;

endpackage

// File: rtl/mvp_accum_lane.sv
// One accumulator lane: sign-extend, shift, optional negate, add.
// Build with MVP_ACCUM_SAT_EN for saturating adds and a sticky ovf flag.
module mvp_accum_lane
  import mvp_pkg::*;
#(
  parameter int SW   = 7,
  parameter int ACCW = DEFAULT_ACCW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               en,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               neg,
  input  logic [SW-1:0]      s_lane,
  output logic [ACCW-1:0]    acc
`ifdef MVP_ACCUM_SAT_EN
  ,
  output logic               ovf
`endif
);

  logic [ACCW-1:0] acc_next;

`ifdef MVP_ACCUM_SAT_EN
  // Sum is formed wide enough that neither the shifted term nor the add can
  // wrap, so clamping sees the true mathematical result.
  localparam int XW = ACCW + SW + MAX_SHIFT + 1;

  logic [XW-1:0] term;
  logic [XW-1:0] sum;
  logic          over;

  always_comb begin
    term = {{(XW-SW){s_lane[SW-1]}}, s_lane} << shift;
    if (neg) term = -term;
    sum  = {{(XW-ACCW){acc[ACCW-1]}}, acc} + term;
    over = (sum[XW-1:ACCW-1] != {(XW-ACCW+1){sum[XW-1]}});
    if (!over)
      acc_next = sum[ACCW-1:0];
    else if (sum[XW-1])
      acc_next = {1'b1, {(ACCW-1){1'b0}}};
    else
      acc_next = {1'b0, {(ACCW-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      acc <= acc_next;
      ovf <= ovf | over;
    end
  end
`else
  logic [ACCW-1:0] term;

  always_comb begin
    term = {{(ACCW-SW){s_lane[SW-1]}}, s_lane} << shift;
    if (neg) term = -term;
    acc_next = acc + term;
  end

  always_ff @(posedge clk) begin
    if (rst || clear)
      acc <= '0;
    else if (en)
      acc <= acc_next;
  end
`endif

endmodule

// File: rtl/mvp_accum.sv
// Bit-serial shift-accumulate stage behind mvp: FSM and bit-plane counters.
// Optional saturation and ovf output enabled by defining MVP_ACCUM_SAT_EN.
module mvp_accum
  import mvp_pkg::*;
#(
  parameter int N    = 32,
  parameter int A    = $clog2(N),
  parameter int ACCW = DEFAULT_ACCW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PREC_W-1:0]     wprec_m1,
  input  logic [PREC_W-1:0]     iprec_m1,
  input  logic                  wsign,
  input  logic                  isign,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [N*(A+2)-1:0]    s_data,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [N*ACCW-1:0]     o_data,
  output logic                  busy
`ifdef MVP_ACCUM_SAT_EN
  ,
  output logic                  ovf
`endif
);

  localparam int SW = A + 2;

  accum_state_t      state;
  logic [PREC_W-1:0] wb;
  logic [PREC_W-1:0] ib;
  logic [PREC_W-1:0] wprec_q;
  logic [PREC_W-1:0] iprec_q;
  logic              wsign_q;
  logic              isign_q;

  logic               beat;
  logic               clear;
  logic [SHIFT_W-1:0] shift;
  logic               neg;

  assign beat  = s_valid && s_ready;
  assign clear = (state == IDLE);
  assign shift = SHIFT_W'(wb) + SHIFT_W'(ib);
  // MSB planes of two's-complement operands carry negative weight.
  assign neg   = (wsign_q && (wb == wprec_q)) ^ (isign_q && (ib == iprec_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wb      <= '0;
      ib      <= '0;
      wprec_q <= '0;
      iprec_q <= '0;
      wsign_q <= 1'b0;
      isign_q <= 1'b0;
      s_ready <= 1'b0;
      o_valid <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= ACCUM;
            wprec_q <= wprec_m1;
            iprec_q <= iprec_m1;
            wsign_q <= wsign;
            isign_q <= isign;
            wb      <= wprec_m1;
            ib      <= iprec_m1;
            s_ready <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ACCUM: begin
          if (beat) begin
            if (ib != '0) begin
              ib <= ib - 1'b1;
            end else if (wb != '0) begin
              wb <= wb - 1'b1;
              ib <= iprec_q;
            end else begin
              state   <= OUT;
              s_ready <= 1'b0;
              o_valid <= 1'b1;
            end
          end
        end
        OUT: begin
          if (o_ready) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            busy    <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          o_valid <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef MVP_ACCUM_SAT_EN
  logic [N-1:0] lane_ovf;
  assign ovf = |lane_ovf;
`endif

  for (genvar i = 0; i < N; i++) begin : g_lane
    mvp_accum_lane #(
      .SW   (SW),
      .ACCW (ACCW)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clear  (clear),
      .en     (beat),
      .shift  (shift),
      .neg    (neg),
      .s_lane (s_data[i*SW +: SW]),
      .acc    (o_data[i*ACCW +: ACCW])
`ifdef MVP_ACCUM_SAT_EN
      ,
      .ovf    (lane_ovf[i])
`endif
    );
  end

endmodule

// File: tb/tb_mvp_accum.sv
// Directed bench for mvp_accum (N=4, ACCW=8) with a result scoreboard queue.
module tb_mvp_accum;

  localparam int N    = 4;
  localparam int A    = 2;
  localparam int SW   = A + 2;
  localparam int ACCW = 8;
  localparam int DW   = N * SW;

  typedef struct {
    logic [N*ACCW-1:0] data;
    logic              ovf;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [2:0]      wprec_m1;
  logic [2:0]      iprec_m1;
  logic            wsign;
  logic            isign;
  logic            s_valid;
  logic            s_ready;
  logic [DW-1:0]   s_data;
  logic            o_valid;
  logic            o_ready;
  logic [N*ACCW-1:0] o_data;
  logic            busy;
`ifdef MVP_ACCUM_SAT_EN
  logic            ovf;
`endif

  exp_t          exp_q[$];
  logic [DW-1:0] beat_q[$];
  int            checks = 0;
  int            passes = 0;
  int            fails  = 0;

  mvp_accum #(.N(N), .A(A), .ACCW(ACCW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .wprec_m1 (wprec_m1),
    .iprec_m1 (iprec_m1),
    .wsign    (wsign),
    .isign    (isign),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_data   (o_data),
    .busy     (busy)
`ifdef MVP_ACCUM_SAT_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkSignal(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) begin
      passes++;
    end else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] lanes4(input int v0, input int v1, input int v2, input int v3);
    logic [DW-1:0] b;
    b = '0;
    b[0*SW +: SW] = SW'(v0);
    b[1*SW +: SW] = SW'(v1);
    b[2*SW +: SW] = SW'(v2);
    b[3*SW +: SW] = SW'(v3);
    return b;
  endfunction

  // Drives one full job from beat_q and pushes the modelled result.
  task automatic applyStimulus(input logic [2:0] wp, input logic [2:0] ip,
                               input logic wsg, input logic isg, input int gap_at);
    int acc_m[N];
    logic ovf_m;
    int nbeats, wbm, ibm, term;
    logic negm;
    logic signed [SW-1:0] sv;
    logic signed [ACCW-1:0] wr;
    exp_t e;
    nbeats = beat_q.size();
    for (int l = 0; l < N; l++) acc_m[l] = 0;
    ovf_m = 1'b0;
    wprec_m1 = wp;
    iprec_m1 = ip;
    wsign = wsg;
    isign = isg;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkSignal("s_ready_after_start", 64'(s_ready), 64'(1));
    checkSignal("busy_after_start", 64'(busy), 64'(1));
    for (int k = 0; k < nbeats; k++) begin
      if (k == gap_at) begin
        s_valid = 1'b0;
        s_data  = DW'($urandom);
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = beat_q[k];
      wbm  = int'(wp) - k / (int'(ip) + 1);
      ibm  = int'(ip) - k % (int'(ip) + 1);
      negm = (wsg && wbm == int'(wp)) ^ (isg && ibm == int'(ip));
      for (int l = 0; l < N; l++) begin
        sv   = beat_q[k][l*SW +: SW];
        term = int'(sv) * (1 << (wbm + ibm));
        if (negm) term = -term;
        acc_m[l] = acc_m[l] + term;
`ifdef MVP_ACCUM_SAT_EN
        if (acc_m[l] > 127) begin
          acc_m[l] = 127;
          ovf_m = 1'b1;
        end else if (acc_m[l] < -128) begin
          acc_m[l] = -128;
          ovf_m = 1'b1;
        end
`else
        wr = ACCW'(acc_m[l]);
        acc_m[l] = int'(wr);
`endif
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_data  = '0;
    for (int l = 0; l < N; l++) e.data[l*ACCW +: ACCW] = ACCW'(acc_m[l]);
    e.ovf = ovf_m;
    exp_q.push_back(e);
    beat_q.delete();
  endtask

  // Waits (bounded) for o_valid, compares against the scoreboard, handshakes.
  task automatic checkOutput(input string tag);
    int waited;
    exp_t e;
    waited = 0;
    while (o_valid !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkSignal({tag, "_latency"}, 64'(waited), 64'(0));
    checkSignal({tag, "_o_valid"}, 64'(o_valid), 64'(1));
    checkSignal({tag, "_s_ready_out"}, 64'(s_ready), 64'(0));
    if (exp_q.size() == 0) begin
      checks++;
      fails++;
      $error("[TB] FAIL %s_scoreboard: observed empty queue, expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      for (int l = 0; l < N; l++)
        checkSignal($sformatf("%s_lane%0d", tag, l),
                    64'(o_data[l*ACCW +: ACCW]), 64'(e.data[l*ACCW +: ACCW]));
`ifdef MVP_ACCUM_SAT_EN
      checkSignal({tag, "_ovf"}, 64'(ovf), 64'(e.ovf));
`endif
    end
    o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
    checkSignal({tag, "_o_valid_after_hs"}, 64'(o_valid), 64'(0));
    checkSignal({tag, "_busy_after_hs"}, 64'(busy), 64'(0));
  endtask

  initial begin
    logic [N*ACCW-1:0] held;
    rst = 1'b1;
    start = 1'b0;
    wprec_m1 = '0;
    iprec_m1 = '0;
    wsign = 1'b0;
    isign = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    o_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkSignal("reset_s_ready", 64'(s_ready), 64'(0));
    checkSignal("reset_o_valid", 64'(o_valid), 64'(0));
    checkSignal("reset_busy", 64'(busy), 64'(0));
    checkSignal("reset_o_data", 64'(o_data), 64'(0));

    // 1x1 unsigned, every lane 5
    beat_q.push_back(lanes4(5, 5, 5, 5));
    applyStimulus(3'd0, 3'd0, 1'b0, 1'b0, -1);
    checkOutput("job1x1");

    // 2x2 unsigned, all ones -> 9
    repeat (4) beat_q.push_back(lanes4(1, 1, 1, 1));
    applyStimulus(3'd1, 3'd1, 1'b0, 1'b0, -1);
    checkOutput("job2x2");

    // signed weights, 2-bit by 1-bit: -6 + 1 = -5 on lane 0
    beat_q.push_back(lanes4(3, 1, 2, -1));
    beat_q.push_back(lanes4(1, 3, -2, 4));
    applyStimulus(3'd1, 3'd0, 1'b1, 1'b0, -1);
    checkOutput("wsign");

    // both signed, mixed lanes, with an s_valid bubble
    beat_q.push_back(lanes4(1, -1, 2, 0));
    beat_q.push_back(lanes4(3, -8, 7, -2));
    beat_q.push_back(lanes4(-2, 5, 1, 7));
    beat_q.push_back(lanes4(-1, 4, -8, 6));
    applyStimulus(3'd1, 3'd1, 1'b1, 1'b1, 2);
    checkOutput("both_signed");

    // 3x2 unsigned exercises the ib wrap across several wb planes
    beat_q.push_back(lanes4(1, 0, 2, 1));
    beat_q.push_back(lanes4(0, 1, 1, 1));
    beat_q.push_back(lanes4(1, 1, 0, 1));
    beat_q.push_back(lanes4(2, 0, 1, 1));
    beat_q.push_back(lanes4(1, 3, 0, 1));
    beat_q.push_back(lanes4(3, 1, 1, 1));
    applyStimulus(3'd2, 3'd1, 1'b0, 1'b0, -1);
    checkOutput("job3x2");

    // backpressure with an ignored start pulse
    beat_q.push_back(lanes4(1, 2, 3, 4));
    applyStimulus(3'd0, 3'd0, 1'b0, 1'b0, -1);
    held = o_data;
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      @(negedge clk);
      start = 1'b0;
      checkSignal($sformatf("bp_hold%0d_o_data", c), 64'(o_data), 64'(held));
      checkSignal($sformatf("bp_hold%0d_s_ready", c), 64'(s_ready), 64'(0));
      checkSignal($sformatf("bp_hold%0d_o_valid", c), 64'(o_valid), 64'(1));
    end
    checkOutput("backpressure");
    checkSignal("bp_start_ignored", 64'(s_ready), 64'(0));

    // reset after 2 of 4 beats aborts the job
    wprec_m1 = 3'd1;
    iprec_m1 = 3'd1;
    wsign = 1'b0;
    isign = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s_valid = 1'b1;
    s_data = lanes4(3, 3, 3, 3);
    repeat (2) @(negedge clk);
    s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkSignal("abort_o_valid", 64'(o_valid), 64'(0));
    checkSignal("abort_busy", 64'(busy), 64'(0));
    checkSignal("abort_s_ready", 64'(s_ready), 64'(0));
    checkSignal("abort_o_data", 64'(o_data), 64'(0));
    beat_q.push_back(lanes4(7, 7, 7, 7));
    applyStimulus(3'd0, 3'd0, 1'b0, 1'b0, -1);
    checkOutput("after_abort");

    // 4x4 unsigned, big first plane overflows the 8-bit accumulator
    beat_q.push_back(lanes4(4, 4, 2, -4));
    repeat (15) beat_q.push_back(lanes4(0, 0, 0, 0));
    applyStimulus(3'd3, 3'd3, 1'b0, 1'b0, -1);
    checkOutput("overflow");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mvp_accum.md
# mvp_accum

Bit-serial shift-accumulate stage directly downstream of `mvp`. It consumes one vector of N per-row partial sums per bit-plane pair (weight bit × input bit) and scales each by its plane significance and sign. It accumulates the scaled values into N wide accumulators and presents the finished N-lane dot-product vector with a valid/ready handshake. Together with `mvp`, it turns a 1-bit matrix-vector product into a multi-precision one.

## Interface
Parameters:
- `N`, 32, number of rows/lanes. Must be a power of 2.
- `A`, `$clog2(N)`, index width. Each partial-sum lane is `A+2` bits.
- `ACCW`, 32, accumulator width per lane, in bits.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle job launch. Honoured only in IDLE.
- `wprec_m1`  in  3  weight precision minus 1 (1..8 bits). Sampled on an accepted `start`.
- `iprec_m1`  in  3  input precision minus 1 (1..8 bits). Sampled on an accepted `start`.
- `wsign`  in  1  weights are two's complement. Sampled on an accepted `start`.
- `isign`  in  1  inputs are two's complement. Sampled on an accepted `start`.
- `s_valid`  in  1  partial-sum beat valid.
- `s_ready`  out  1  partial-sum beat accepted when `s_valid && s_ready`.
- `s_data`  in  N*(A+2)  `mvp` `S` vector. Lane i is at `[i*(A+2) +: A+2]`, signed two's complement.
- `o_valid`  out  1  result valid.
- `o_ready`  in  1  result consumed when `o_valid && o_ready`.
- `o_data`  out  N*ACCW  result. Lane i is at `[i*ACCW +: ACCW]`, signed.
- `busy`  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, ACCUM, OUT.
- IDLE:
  - `start` → ACCUM on the next edge.
  - All accumulators clear to 0.
  - Precision and sign config is latched.
  - `wb` is set to `wprec_m1` and `ib` to `iprec_m1`.
- ACCUM:
  - `s_ready` = 1.
  - Each accepted beat updates every lane: `acc_i += ±(sext(s_data_i) << (wb+ib))`.
  - The term is negated when `(wsign && wb==wprec_m1) XOR (isign && ib==iprec_m1)`. This is the MSB-plane negative weight.
- Beat order:
  - Outer loop is `wb`, descending from MSB to 0. Inner loop is `ib`, descending from MSB to 0.
  - `ib` wraps to `iprec_m1` when `wb` decrements.
  - Total beats per job = (wprec_m1+1)·(iprec_m1+1).
- Final beat is the accepted beat with `wb==0 && ib==0`. The next state is OUT.
- OUT:
  - `o_valid` = 1 and `s_ready` = 0.
  - `o_data` is stable until a handshake.
  - Handshake → IDLE.
- Arithmetic:
  - Maximum shift is 14.
  - The term is sign-extended to ACCW before the shift.
  - Without saturation, overflow wraps modulo 2^ACCW.
- `start` is ignored in ACCUM and OUT.
- `s_valid` is ignored outside ACCUM.
- Reset values:
  - state = IDLE.
  - `s_ready` = 0, `o_valid` = 0, `busy` = 0.
  - `o_data` = 0.
  - All counters = 0.
- Reset mid-job aborts immediately. There is no partial output, and the next job starts clean.

## Timing
- `start` at edge k → `s_ready` = 1 from cycle k+1.
- Beat accepted at edge t → the accumulator is updated at t+1.
- Final beat at edge t → `o_valid` = 1 in cycle t+1, with `o_data` final.
- One beat per cycle at full throughput. Job latency = beats + 1 cycles from the first `s_ready`.
- `o_valid && o_ready` at edge u → IDLE at u+1. A new `start` is accepted from cycle u+1.
- `s_ready` is registered and does not combinationally depend on `s_valid` or `o_ready`.

## Configuration
- `MVP_ACCUM_SAT_EN`:
  - Defined: each lane update saturates to [-2^(ACCW-1), 2^(ACCW-1)-1].
  - Defined: a sticky per-job overflow bit is ORed across lanes and exposed as the extra output `ovf`. `ovf` is valid with `o_valid` and clears on `start`.
  - Undefined: the update wraps, and the `ovf` port is absent.

## Structure
- Shared package `mvp_pkg` holds:
  - the FSM state enum `accum_state_t` (IDLE, ACCUM, OUT);
  - `PREC_W` = 3;
  - `MAX_SHIFT` = 14;
  - the default `ACCW`.
- Sub-module `mvp_accum_lane`:
  - one lane: sign-extend, shift, conditional negate, add, and optional saturation;
  - instantiated N times via generate;
  - the top keeps the FSM and the `wb`/`ib` counters.

## Test plan
- 1×1 unsigned, all lanes `s_data` = 5 → `o_valid` 1 cycle after the beat, every lane = 5.
- 2×2 unsigned, beats S = 1, 1, 1, 1 (shifts 2, 1, 1, 0) → every lane = 9.
- `wsign`=1, wprec 2, iprec 1, beats S = 3 then 1 → lane = -6+1 = -5.
- Backpressure: hold `o_ready`=0 for 5 cycles with `start` pulsed → `o_data` stable, `s_ready`=0, `start` ignored. After release → IDLE, then a new job is accepted.
- `rst` after 2 of 4 beats of a 2×2 job → `o_valid`=0 and `busy`=0. The next 1×1 job with S=7 yields 7.
- ACCW=8, 4×4 unsigned, first beat S=4 (shift 6), the rest 0:
  - with `MVP_ACCUM_SAT_EN`: lane = 127, `ovf`=1;
  - without it: lane = 0.
